imem_sync_loadable: RTL and testbench

Parametrised successor to the Cardinal core instruction memory: synchronous-read instruction store with a 1-cycle registered fetch path and a stall-hold output. Adds a streaming program-load port with valid/ready handshake and an auto-incrementing write pointer, so programs can be loaded through the ring NIC without testbench backdoor $readmemh. Sits between the NIC/loader and the processor fetch stage. A load-mode state machine holds the core (cpu_hold) while loading.

---
 rtl/imem_sync_loadable_if.sv | 30 +++
 rtl/imem_sync_loadable.sv | 93 +++++++++
 tb/tb_imem_sync_loadable.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_sync_loadable_if.sv
// Fetch and program-load signal bundle between the loader/fetch side (master) and the
// instruction memory (slave).
interface imem_sync_loadable_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              load_req;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              cpu_hold;
    logic [ADDR_W:0]   load_cnt;
    logic              load_ovf;

    modport master (
        output fetch_en, fetch_addr, load_req, load_base, load_valid, load_data, load_last,
        input  fetch_data, fetch_valid, load_ready, cpu_hold, load_cnt, load_ovf
    );

    modport slave (
        input  fetch_en, fetch_addr, load_req, load_base, load_valid, load_data, load_last,
        output fetch_data, fetch_valid, load_ready, cpu_hold, load_cnt, load_ovf
    );
endinterface

// File: rtl/imem_sync_loadable.sv
// Loadable instruction store: streamed program load, then 1-cycle registered fetch with stall hold.
// Load words are accepted every cycle while in LOAD (load_ready=1); no load words are accepted in RUN.
module imem_sync_loadable #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    imem_sync_loadable_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              xfer;
    logic              load_ready;
    logic              cpu_hold;
    logic              enter_load;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   load_cnt;
    logic              load_ovf;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cpu_hold   = 1'b0;
        xfer       = 1'b0;
        enter_load = 1'b0;
        case (state)
            ST_LOAD: begin
                load_ready = 1'b1;
                cpu_hold   = 1'b1;
                xfer       = bus.load_valid;
                if (bus.load_valid && bus.load_last) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (bus.load_req) begin
                    enter_load = 1'b1;
                    state_nxt  = ST_LOAD;
                end
            end
            default: state_nxt = ST_LOAD;
        endcase
    end

    // Write pointer and session counters restart from load_base on every LOAD entry.
    always_ff @(posedge clk) begin
        if (reset || enter_load) begin
            wptr     <= bus.load_base;
            load_cnt <= '0;
            load_ovf <= 1'b0;
        end else if (xfer) begin
            wptr <= wptr + ADDR_W'(1);
            if (load_cnt == CNT_MAX) load_ovf <= 1'b1;
            else                     load_cnt <= load_cnt + (ADDR_W+1)'(1);
        end
    end

    // Array has no reset so a program survives a core reset; the reset cycle itself never writes.
    always_ff @(posedge clk) begin
        if (xfer && !reset) mem[wptr] <= bus.load_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_data  <= '0;
            fetch_valid <= 1'b0;
        end else if (state == ST_RUN && bus.fetch_en) begin
            fetch_data  <= mem[bus.fetch_addr];
            fetch_valid <= 1'b1;
        end else begin
            fetch_valid <= 1'b0;
        end
    end

    assign bus.fetch_data  = fetch_data;
    assign bus.fetch_valid = fetch_valid;
    assign bus.load_ready  = load_ready;
    assign bus.cpu_hold    = cpu_hold;
    assign bus.load_cnt    = load_cnt;
    assign bus.load_ovf    = load_ovf;
endmodule

// File: tb/tb_imem_sync_loadable.sv
// Bench for imem_sync_loadable: a 256-word instance against an array model, plus a 4-word
// instance for counter saturation and overflow.
module tb_imem_sync_loadable;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    imem_sync_loadable_if #(.DATA_W(32), .ADDR_W(8)) ia();
    imem_sync_loadable_if #(.DATA_W(32), .ADDR_W(2)) ib();

    imem_sync_loadable #(.DATA_W(32), .ADDR_W(8)) dut_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    imem_sync_loadable #(.DATA_W(32), .ADDR_W(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ib.slave));

    int errors = 0;
    int checks = 0;

    // Reference model of the 256-word instance
    logic [31:0] ref_mem [256];
    int          ref_wptr;
    int          ref_cnt;
    bit          ref_ovf;
    bit          ref_run;
    logic [31:0] ref_fdata;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        ref_wptr  = int'(ia.load_base);
        ref_cnt   = 0;
        ref_ovf   = 1'b0;
        ref_run   = 1'b0;
        ref_fdata = '0;
    endtask

    task automatic enter_load_a(input logic [7:0] base);
        ia.load_req  = 1'b1;
        ia.load_base = base;
        step();
        ia.load_req = 1'b0;
        ref_run  = 1'b0;
        ref_wptr = int'(base);
        ref_cnt  = 0;
        ref_ovf  = 1'b0;
        ia.load_base = 8'($urandom);
    endtask

    task automatic xfer_a(input logic [31:0] d, input bit last);
        logic [10:0] exp_st;
        ia.load_valid = 1'b1;
        ia.load_data  = d;
        ia.load_last  = last;
        step();
        ia.load_valid = 1'b0;
        ia.load_last  = 1'b0;
        if (!ref_run) begin
            ref_mem[ref_wptr] = d;
            ref_wptr = (ref_wptr + 1) % 256;
            if (ref_cnt == 256) ref_ovf = 1'b1;
            else                ref_cnt = ref_cnt + 1;
            if (last) ref_run = 1'b1;
        end
        exp_st = {9'(ref_cnt), ref_ovf, !ref_run};
        checks++;
        if ({ia.load_cnt, ia.load_ovf, ia.cpu_hold} !== exp_st) begin
            errors++;
            $display("FAIL load_status cnt/ovf/hold got %h/%b/%b want %h/%b/%b",
                     ia.load_cnt, ia.load_ovf, ia.cpu_hold, exp_st[10:2], exp_st[1], exp_st[0]);
        end
    endtask

    task automatic fetch_a(input bit en, input logic [7:0] a);
        bit exp_v;
        ia.fetch_en   = en;
        ia.fetch_addr = a;
        step();
        ia.fetch_en = 1'b0;
        exp_v = ref_run && en;
        if (exp_v) ref_fdata = ref_mem[a];
        checks++;
        if (ia.fetch_data !== ref_fdata || ia.fetch_valid !== exp_v) begin
            errors++;
            $display("FAIL fetch addr=%h en=%b got data=%h valid=%b want data=%h valid=%b",
                     a, en, ia.fetch_data, ia.fetch_valid, ref_fdata, exp_v);
        end
    endtask

    task automatic test_reset();
        ia.load_base = 8'h10;
        reset_a();
        checks++;
        if (ia.fetch_data !== 32'h0 || ia.fetch_valid !== 1'b0 || ia.load_ready !== 1'b1 ||
            ia.cpu_hold !== 1'b1 || ia.load_cnt !== 9'h0 || ia.load_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got data=%h valid=%b ready=%b hold=%b cnt=%h ovf=%b want 0/0/1/1/0/0",
                     ia.fetch_data, ia.fetch_valid, ia.load_ready, ia.cpu_hold, ia.load_cnt, ia.load_ovf);
        end
    endtask

    task automatic test_load_basic();
        for (int i = 1; i <= 4; i++) xfer_a(32'hA000_0000 + 32'(i), i == 4);
        checks++;
        if (ia.load_ready !== 1'b0 || ia.load_cnt !== 9'd4) begin
            errors++;
            $display("FAIL run_entry got ready=%b cnt=%0d want ready=0 cnt=4", ia.load_ready, ia.load_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) fetch_a(1'b1, 8'h10 + 8'(i));
        checks++;
        if (ia.fetch_data !== 32'hA000_0004) begin
            errors++;
            $display("FAIL fetch_0x13 got %h want a0000004", ia.fetch_data);
        end
        for (int i = 0; i < 3; i++) fetch_a(1'b0, 8'($urandom));
    endtask

    task automatic test_wrap();
        ia.fetch_en   = 1'b1;
        ia.fetch_addr = 8'h11;
        ia.load_req   = 1'b1;
        ia.load_base  = 8'hFE;
        step();
        ia.fetch_en = 1'b0;
        ia.load_req = 1'b0;
        ia.load_base = 8'h33;
        ref_fdata = ref_mem[8'h11];
        ref_run = 1'b0; ref_wptr = 8'hFE; ref_cnt = 0; ref_ovf = 1'b0;
        checks++;
        if (ia.fetch_valid !== 1'b1 || ia.fetch_data !== 32'hA000_0002 ||
            ia.cpu_hold !== 1'b1 || ia.load_cnt !== 9'd0) begin
            errors++;
            $display("FAIL load_req_entry got valid=%b data=%h hold=%b cnt=%0d want 1/a0000002/1/0",
                     ia.fetch_valid, ia.fetch_data, ia.cpu_hold, ia.load_cnt);
        end
        for (int i = 0; i < 3; i++) xfer_a($urandom, i == 2);
        checks++;
        if (ia.load_cnt !== 9'd3 || ia.load_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_cnt got cnt=%0d ovf=%b want 3/0", ia.load_cnt, ia.load_ovf);
        end
        fetch_a(1'b1, 8'hFE);
        fetch_a(1'b1, 8'hFF);
        fetch_a(1'b1, 8'h00);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [7:0] base;
            int n;
            base = 8'($urandom);
            n = int'($urandom_range(1, 6));
            enter_load_a(base);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    // Idle cycle in LOAD: stray last, load_req and fetch must all be ignored
                    ia.load_last  = 1'($urandom);
                    ia.load_req   = 1'($urandom);
                    ia.load_base  = 8'($urandom);
                    ia.fetch_en   = 1'($urandom);
                    ia.fetch_addr = 8'($urandom);
                    step();
                    ia.load_last = 1'b0; ia.load_req = 1'b0; ia.fetch_en = 1'b0;
                    checks++;
                    if (ia.cpu_hold !== 1'b1 || ia.load_cnt !== 9'(ref_cnt) ||
                        ia.fetch_valid !== 1'b0 || ia.fetch_data !== ref_fdata) begin
                        errors++;
                        $display("FAIL load_idle got hold=%b cnt=%0d valid=%b data=%h want 1/%0d/0/%h",
                                 ia.cpu_hold, ia.load_cnt, ia.fetch_valid, ia.fetch_data, ref_cnt, ref_fdata);
                    end
                end
                xfer_a($urandom, i == n - 1);
            end
            for (int k = 0; k < 5; k++)
                fetch_a(1'($urandom_range(0, 3) != 0), base + 8'($urandom_range(0, n - 1)));
        end
    endtask

    task automatic test_reset_mid_load();
        enter_load_a(8'h40);
        for (int i = 0; i < 3; i++) xfer_a($urandom, i == 2);
        enter_load_a(8'h40);
        xfer_a($urandom, 1'b0);
        xfer_a($urandom, 1'b0);
        ia.load_valid = 1'b1;
        ia.load_data  = 32'hBADB_AD00;
        ia.load_base  = 8'h50;
        reset_a();
        ia.load_valid = 1'b0;
        checks++;
        if (ia.load_cnt !== 9'd0 || ia.cpu_hold !== 1'b1 || ia.load_ready !== 1'b1 ||
            ia.fetch_data !== 32'h0) begin
            errors++;
            $display("FAIL mid_load_reset got cnt=%0d hold=%b ready=%b data=%h want 0/1/1/0",
                     ia.load_cnt, ia.cpu_hold, ia.load_ready, ia.fetch_data);
        end
        xfer_a($urandom, 1'b1);
        fetch_a(1'b1, 8'h40);
        fetch_a(1'b1, 8'h41);
        fetch_a(1'b1, 8'h42);
        fetch_a(1'b1, 8'h50);
    endtask

    task automatic test_ovf();
        logic [31:0] w [5];
        logic [31:0] exp_mem [4];
        ib.load_base = 2'd1;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            w[i] = $urandom;
            ib.load_valid = 1'b1;
            ib.load_data  = w[i];
            ib.load_last  = (i == 4);
            step();
            checks++;
            if (ib.load_cnt !== 3'((i + 1 > 4) ? 4 : i + 1) || ib.load_ovf !== (i == 4)) begin
                errors++;
                $display("FAIL small_cnt word=%0d got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                         i, ib.load_cnt, ib.load_ovf, (i + 1 > 4) ? 4 : i + 1, i == 4);
            end
        end
        ib.load_valid = 1'b0;
        ib.load_last  = 1'b0;
        // base 1, five writes land on addresses 1,2,3,0,1
        exp_mem[0] = w[3]; exp_mem[1] = w[4]; exp_mem[2] = w[1]; exp_mem[3] = w[2];
        for (int a = 0; a < 4; a++) begin
            ib.fetch_en   = 1'b1;
            ib.fetch_addr = 2'(a);
            step();
            checks++;
            if (ib.fetch_data !== exp_mem[a] || ib.fetch_valid !== 1'b1 || ib.cpu_hold !== 1'b0) begin
                errors++;
                $display("FAIL small_fetch addr=%0d got %h valid=%b hold=%b want %h/1/0",
                         a, ib.fetch_data, ib.fetch_valid, ib.cpu_hold, exp_mem[a]);
            end
        end
        ib.fetch_en = 1'b0;
        ib.load_req = 1'b1;
        step();
        ib.load_req = 1'b0;
        checks++;
        if (ib.load_ovf !== 1'b0 || ib.load_cnt !== 3'd0 || ib.cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clear got ovf=%b cnt=%0d hold=%b want 0/0/1",
                     ib.load_ovf, ib.load_cnt, ib.cpu_hold);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        ia.fetch_en = 1'b0; ia.fetch_addr = '0; ia.load_req = 1'b0; ia.load_base = '0;
        ia.load_valid = 1'b0; ia.load_data = '0; ia.load_last = 1'b0;
        ib.fetch_en = 1'b0; ib.fetch_addr = '0; ib.load_req = 1'b0; ib.load_base = '0;
        ib.load_valid = 1'b0; ib.load_data = '0; ib.load_last = 1'b0;

        test_reset();
        test_load_basic();
        test_back_to_back();
        test_wrap();
        test_random();
        test_reset_mid_load();
        test_ovf();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
